// File: rtl/mat_drain.sv
// Drains a captured M x K signed matrix as a row-major element stream,
// optionally skipping zero elements with no bubble cycles.

module mat_drain_nz #(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] elem,
  output logic                nz
);
  assign nz = |elem;
endmodule

module mat_drain #(
  parameter int DATA_LEN = 32,
  parameter int M        = 8,
  parameter int K        = 8,
  parameter int ROW_SIZE = DATA_LEN*K,
  parameter int MAT_SIZE = DATA_LEN*K*M
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_load,
  input  logic                              i_skip_zero,
  input  logic [MAT_SIZE-1:0]               i_mat,
  output logic                              o_load_ready,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [DATA_LEN-1:0]               o_data,
  output logic [((M>1)?$clog2(M):1)-1:0]    o_row,
  output logic [((K>1)?$clog2(K):1)-1:0]    o_col,
  output logic                              o_last,
  output logic                              o_empty
);
  localparam int N  = M*K;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } hit_t;

  state_t        state;
  logic [MAT_SIZE-1:0] mat;
  logic [N-1:0]  mask;
  logic [IW-1:0] idx;

  logic [N-1:0]  nz;
  logic [N-1:0]  load_mask;
  hit_t          load_hit, nxt_hit;
  logic          load_more, nxt_more;

  // Lowest set bit at or above start; row/col come out of the scan directly
  // so no divider is needed for non-power-of-two K.
  function automatic hit_t first_set(input logic [N-1:0] m, input int start);
    hit_t h;
    h = '0;
    for (int r = M-1; r >= 0; r--) begin
      for (int c = K-1; c >= 0; c--) begin
        if (m[r*K+c] && (r*K+c) >= start) begin
          h.found = 1'b1;
          h.idx   = IW'(r*K+c);
          h.row   = RW'(r);
          h.col   = CW'(c);
        end
      end
    end
    return h;
  endfunction

  generate
    for (genvar g = 0; g < N; g++) begin : g_nz
      mat_drain_nz #(.DATA_LEN(DATA_LEN)) u_nz (
        .elem (i_mat[g*DATA_LEN +: DATA_LEN]),
        .nz   (nz[g])
      );
    end
  endgenerate

  always_comb begin
    load_mask = i_skip_zero ? nz : {N{1'b1}};
    load_hit  = first_set(load_mask, 0);
    load_more = first_set(load_mask, int'(load_hit.idx) + 1).found;
    nxt_hit   = first_set(mask, int'(idx) + 1);
    nxt_more  = first_set(mask, int'(nxt_hit.idx) + 1).found;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      mask         <= '0;
      idx          <= '0;
      o_load_ready <= 1'b1;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_row        <= '0;
      o_col        <= '0;
      o_last       <= 1'b0;
      o_empty      <= 1'b0;
    end else begin
      o_empty <= 1'b0;
      case (state)
        IDLE: begin
          if (i_load) begin
            mat  <= i_mat;
            mask <= load_mask;
            if (load_hit.found) begin
              // Slice comes from i_mat since mat is only being written now
              state        <= SEND;
              idx          <= load_hit.idx;
              o_load_ready <= 1'b0;
              o_valid      <= 1'b1;
              o_data       <= i_mat[int'(load_hit.idx)*DATA_LEN +: DATA_LEN];
              o_row        <= load_hit.row;
              o_col        <= load_hit.col;
              o_last       <= ~load_more;
            end else begin
              o_empty <= 1'b1;
            end
          end
        end
        SEND: begin
          if (i_ready) begin
            if (o_last) begin
              state        <= IDLE;
              o_load_ready <= 1'b1;
              o_valid      <= 1'b0;
              o_last       <= 1'b0;
            end else begin
              idx    <= nxt_hit.idx;
              o_data <= mat[int'(nxt_hit.idx)*DATA_LEN +: DATA_LEN];
              o_row  <= nxt_hit.row;
              o_col  <= nxt_hit.col;
              o_last <= ~nxt_more;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_drain.sv
// Directed bench for mat_drain at default 32-bit 8x8 geometry.

module tb_mat_drain;
  localparam int DL = 32;
  localparam int MM = 8;
  localparam int KK = 8;
  localparam int MS = DL*KK*MM;

  logic          clk = 1'b0;
  logic          rst, load, skip_zero, ready;
  logic [MS-1:0] mat;
  logic          load_ready, valid, last, empty;
  logic [DL-1:0] data;
  logic [2:0]    row, col;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mat_drain #(.DATA_LEN(DL), .M(MM), .K(KK)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load       (load),
    .i_skip_zero  (skip_zero),
    .i_mat        (mat),
    .o_load_ready (load_ready),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_data       (data),
    .o_row        (row),
    .o_col        (col),
    .o_last       (last),
    .o_empty      (empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input int r, input int c,
                      input logic [31:0] v, input logic l);
    chk({tag, " valid"}, 32'(valid), 32'd1);
    chk({tag, " data"},  data, v);
    chk({tag, " row"},   32'(row), 32'(r));
    chk({tag, " col"},   32'(col), 32'(c));
    chk({tag, " last"},  32'(last), 32'(l));
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < MM*KK; i++) mat[i*DL +: DL] = 32'(base + i);
  endtask

  task automatic do_load(input logic skip);
    load = 1'b1; skip_zero = skip;
    tick();
    load = 1'b0; skip_zero = 1'b0;
  endtask

  initial begin
    int e;
    int cyc;
    rst = 1'b1; load = 1'b0; skip_zero = 1'b0; ready = 1'b0; mat = '0;
    tick(); tick();
    chk("rst load_ready", 32'(load_ready), 32'd1);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst empty", 32'(empty), 32'd0);
    chk("rst last", 32'(last), 32'd0);
    chk("rst data", data, 32'd0);
    chk("rst rowcol", {26'd0, row, col}, 32'd0);
    rst = 1'b0;
    tick();

    // Non-skip ramp, consumer always ready: 64 consecutive beats
    fill_ramp(0);
    ready = 1'b1;
    do_load(1'b0);
    chk("ramp load_ready", 32'(load_ready), 32'd0);
    for (int b = 0; b < 64; b++) begin
      beat("ramp", b / 8, b % 8, 32'(b), b == 63);
      tick();
    end
    chk("ramp end valid", 32'(valid), 32'd0);
    chk("ramp end load_ready", 32'(load_ready), 32'd1);
    tick();

    // Skip mode, three sparse nonzeros, back-to-back
    mat = '0;
    mat[(0*8+3)*DL +: DL] = 32'd5;
    mat[(2*8+0)*DL +: DL] = 32'hFFFF_FFF9;
    mat[(7*8+7)*DL +: DL] = 32'd9;
    do_load(1'b1);
    beat("sparse0", 0, 3, 32'd5, 1'b0);          tick();
    beat("sparse1", 2, 0, 32'hFFFF_FFF9, 1'b0);  tick();
    beat("sparse2", 7, 7, 32'd9, 1'b1);          tick();
    chk("sparse end valid", 32'(valid), 32'd0);
    chk("sparse end load_ready", 32'(load_ready), 32'd1);

    // Skip mode, all-zero matrix
    mat = '0;
    do_load(1'b1);
    chk("zero empty", 32'(empty), 32'd1);
    chk("zero valid", 32'(valid), 32'd0);
    chk("zero load_ready", 32'(load_ready), 32'd1);
    tick();
    chk("zero empty pulse", 32'(empty), 32'd0);
    chk("zero valid2", 32'(valid), 32'd0);
    chk("zero load_ready2", 32'(load_ready), 32'd1);

    // Stall pattern 1,0,0,1,0,0 on i_ready; hold and no loss/dup
    fill_ramp(1000);
    ready = 1'b0;
    do_load(1'b0);
    e = 0; cyc = 0;
    while (e < 64 && cyc < 400) begin
      ready = (cyc % 3 == 0);
      beat("stall", e / 8, e % 8, 32'(1000 + e), e == 63);
      if (ready) e++;
      cyc++;
      tick();
    end
    chk("stall done", 32'(e), 32'd64);
    chk("stall end valid", 32'(valid), 32'd0);
    ready = 1'b1;

    // Mid-SEND load ignored; reset after beat 10 abandons the matrix
    fill_ramp(0);
    do_load(1'b0);
    for (int b = 0; b <= 10; b++) begin
      beat("midload", b / 8, b % 8, 32'(b), 1'b0);
      if (b == 3) begin
        fill_ramp(500); load = 1'b1; skip_zero = 1'b1;
      end else begin
        load = 1'b0; skip_zero = 1'b0;
      end
      if (b == 10) rst = 1'b1;
      tick();
    end
    load = 1'b0;
    chk("abort valid", 32'(valid), 32'd0);
    chk("abort load_ready", 32'(load_ready), 32'd1);
    chk("abort data", data, 32'd0);
    chk("abort rowcol", {26'd0, row, col}, 32'd0);
    rst = 1'b0;
    tick();
    chk("abort stays idle", 32'(valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
